// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, ALUop
// encodings, controller states and the state-decoded datapath controls.
package mips_ctrl_pkg;

    localparam int STATE_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_R_EXEC    = 4'd3,
        S_R_WB      = 4'd4,
        S_MEM_ADDR  = 4'd5,
        S_MEM_RD    = 4'd6,
        S_MEM_WB    = 4'd7,
        S_MEM_WR    = 4'd8,
        S_ADDI_EXEC = 4'd9,
        S_ADDI_WB   = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12
    } state_t;

    typedef struct packed {
        logic [1:0] aluop;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } moore_t;

    function automatic logic is_legal_op(logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_ADDI)  || (op == OP_BEQ) || (op == OP_BNE) ||
               (op == OP_BGTZ)  || (op == OP_J);
    endfunction

    // Controls that depend only on the state; fields a state does not use stay 0.
    function automatic moore_t moore_decode(state_t s);
        moore_t m;
        m = '0;
        case (s)
            S_FETCH: begin
                m.mem_read  = 1'b1;
                m.alu_src_b = 2'b01;
                m.aluop     = ALUOP_ADD;
            end
            S_DECODE:    m.alu_src_b = 2'b11;
            S_R_EXEC: begin
                m.alu_src_a = 1'b1;
                m.aluop     = ALUOP_FUNC;
            end
            S_R_WB: begin
                m.reg_dst   = 1'b1;
                m.reg_write = 1'b1;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                m.alu_src_a = 1'b1;
                m.alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                m.mem_read = 1'b1;
                m.iord     = 1'b1;
            end
            S_MEM_WB: begin
                m.mem_to_reg = 1'b1;
                m.reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                m.mem_write = 1'b1;
                m.iord      = 1'b1;
            end
            S_ADDI_WB:   m.reg_write = 1'b1;
            S_BRANCH: begin
                m.alu_src_a = 1'b1;
                m.aluop     = ALUOP_SUB;
                m.pc_source = 2'b01;
            end
            S_JUMP:      m.pc_source = 2'b10;
            default:     m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch-taken decision for beq / bne / bgtz from the ALU compare flags.
module branch_cond
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       alu_zero,
    input  logic       alu_neg,
    output logic       take
);

    assign take = ((opcode == OP_BEQ)  &&  alu_zero) ||
                  ((opcode == OP_BNE)  && !alu_zero) ||
                  ((opcode == OP_BGTZ) && !alu_zero && !alu_neg);

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle main controller: sequences fetch/decode/execute/memory/writeback
// and produces ALUop plus every datapath enable, mux select and write strobe.
module multicycle_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int ST_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       alu_zero,
    input  logic       alu_neg,
    input  logic       mem_ready,
    output logic [1:0] ALUop,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal_op
);

    logic [ST_W-1:0] state_reg;
    state_t          state;
    state_t          state_next;
    moore_t          moore_reg;
    logic            take;

    assign state = state_t'(state_reg);

    branch_cond u_branch_cond (
        .opcode   (opcode),
        .alu_zero (alu_zero),
        .alu_neg  (alu_neg),
        .take     (take)
    );

    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE:     state_next = S_FETCH;
            S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                state_next = S_R_EXEC;
                    OP_LW, OP_SW:            state_next = S_MEM_ADDR;
                    OP_ADDI:                 state_next = S_ADDI_EXEC;
                    OP_BEQ, OP_BNE, OP_BGTZ: state_next = S_BRANCH;
                    OP_J:                    state_next = S_JUMP;
                    default:                 state_next = S_FETCH;
                endcase
            end
            S_R_EXEC:    state_next = S_R_WB;
            S_MEM_ADDR:  state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:    state_next = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:    state_next = mem_ready ? S_FETCH : S_MEM_WR;
            S_ADDI_EXEC: state_next = S_ADDI_WB;
            S_R_WB, S_MEM_WB, S_ADDI_WB, S_BRANCH, S_JUMP:
                         state_next = S_FETCH;
            default:     state_next = S_IDLE;
        endcase
    end

    // Moore controls are registered from the next state so they line up with
    // the state register without a decode path after the flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_W'(S_IDLE);
            moore_reg <= '0;
        end else begin
            state_reg <= ST_W'(state_next);
            moore_reg <= moore_decode(state_next);
        end
    end

    assign ALUop      = moore_reg.aluop;
    assign alu_src_a  = moore_reg.alu_src_a;
    assign alu_src_b  = moore_reg.alu_src_b;
    assign pc_source  = moore_reg.pc_source;
    assign iord       = moore_reg.iord;
    assign mem_read   = moore_reg.mem_read;
    assign mem_write  = moore_reg.mem_write;
    assign reg_dst    = moore_reg.reg_dst;
    assign mem_to_reg = moore_reg.mem_to_reg;
    assign reg_write  = moore_reg.reg_write;

    // Strobes qualified by same-cycle inputs cannot be registered.
    assign ir_write   = (state == S_FETCH) && mem_ready;
    assign pc_write   = ir_write || (state == S_JUMP) || ((state == S_BRANCH) && take);
    assign illegal_op = (state == S_DECODE) && !is_legal_op(opcode);
    assign instr_done = (state == S_R_WB) || (state == S_MEM_WB) || (state == S_ADDI_WB) ||
                        (state == S_BRANCH) || (state == S_JUMP) ||
                        ((state == S_MEM_WR) && mem_ready) || illegal_op;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench: each stimulus cycle queues its inputs and the expected
// output vector; the scenario task pops, drives, and compares at negedge.
module tb_multicycle_main_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       alu_zero = 1'b0;
    logic       alu_neg = 1'b0;
    logic       mem_ready = 1'b0;
    logic [1:0] ALUop;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
    logic       illegal_op;

    multicycle_main_control #(.ST_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero),
        .alu_neg(alu_neg), .mem_ready(mem_ready), .ALUop(ALUop),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_write(pc_write),
        .pc_source(pc_source), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .instr_done(instr_done), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // {ALUop, src_a, src_b, pc_write, pc_source, iord, mem_read, mem_write,
    //  ir_write, reg_dst, mem_to_reg, reg_write, instr_done, illegal_op}
    logic [16:0] obs;
    assign obs = {ALUop, alu_src_a, alu_src_b, pc_write, pc_source, iord, mem_read,
                  mem_write, ir_write, reg_dst, mem_to_reg, reg_write, instr_done, illegal_op};

    typedef struct {
        string       tag;
        logic [5:0]  op;
        logic        rdy;
        logic        zero;
        logic        neg;
        logic [16:0] exp;
    } item_t;

    item_t sb[$];
    item_t it;
    int    total = 0;
    int    passed = 0;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, ADDI = 6'b001000;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, BGTZ = 6'b000111, JMP = 6'b000010;

    function automatic logic [16:0] mk(logic [1:0] aop, logic sa, logic [1:0] sbb, logic pcw,
                                       logic [1:0] pcs, logic io, logic mr, logic mw, logic irw,
                                       logic rd, logic m2r, logic rw, logic dn, logic il);
        return {aop, sa, sbb, pcw, pcs, io, mr, mw, irw, rd, m2r, rw, dn, il};
    endfunction

    function automatic logic [16:0] e_fetch(logic r);
        return mk(2'b00, 0, 2'b01, r, 2'b00, 0, 1, 0, r, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [16:0] e_decode(logic il);
        return mk(2'b00, 0, 2'b11, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, il, il);
    endfunction
    function automatic logic [16:0] e_memwr(logic r);
        return mk(2'b00, 0, 2'b00, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, r, 0);
    endfunction
    function automatic logic [16:0] e_branch(logic t);
        return mk(2'b01, 1, 2'b00, t, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endfunction

    localparam logic [16:0] E_IDLE   = 17'd0;
    localparam logic [16:0] E_REXEC  = {2'b10, 1'b1, 2'b00, 12'd0};
    localparam logic [16:0] E_RWB    = 17'b00_0_00_0_00_0_0_0_0_1_0_1_1_0;
    localparam logic [16:0] E_ADDR   = {2'b00, 1'b1, 2'b10, 12'd0};
    localparam logic [16:0] E_MEMRD  = 17'b00_0_00_0_00_1_1_0_0_0_0_0_0_0;
    localparam logic [16:0] E_MEMWB  = 17'b00_0_00_0_00_0_0_0_0_0_1_1_1_0;
    localparam logic [16:0] E_ADDIWB = 17'b00_0_00_0_00_0_0_0_0_0_0_1_1_0;
    localparam logic [16:0] E_JUMP   = 17'b00_0_00_1_10_0_0_0_0_0_0_0_1_0;

    task automatic push(string tag, logic [5:0] op, logic rdy, logic zero, logic neg,
                        logic [16:0] exp);
        item_t x;
        x.tag = tag; x.op = op; x.rdy = rdy; x.zero = zero; x.neg = neg; x.exp = exp;
        sb.push_back(x);
    endtask

    task automatic push_branch(string tag, logic [5:0] op, logic zero, logic neg, logic t);
        push({tag, "_fetch"},  op, 1, zero, neg, e_fetch(1));
        push({tag, "_decode"}, op, 1, zero, neg, e_decode(0));
        push({tag, "_branch"}, op, 1, zero, neg, e_branch(t));
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== E_IDLE) $display("FAIL reset_held: got %b expected %b", obs, E_IDLE);
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        push("idle_after_release", LW, 1, 0, 0, E_IDLE);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            opcode = it.op; mem_ready = it.rdy; alu_zero = it.zero; alu_neg = it.neg;
            @(negedge clk);
            total++;
            if (obs !== it.exp) $display("FAIL %s: got %b expected %b", it.tag, obs, it.exp);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw();
        push("lw_fetch",  LW, 1, 0, 0, e_fetch(1));
        push("lw_decode", LW, 1, 0, 0, e_decode(0));
        push("lw_addr",   LW, 1, 0, 0, E_ADDR);
        push("lw_memrd",  LW, 1, 0, 0, E_MEMRD);
        push("lw_memwb",  LW, 1, 0, 0, E_MEMWB);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            opcode = it.op; mem_ready = it.rdy; alu_zero = it.zero; alu_neg = it.neg;
            @(negedge clk);
            total++;
            if (obs !== it.exp) $display("FAIL %s: got %b expected %b", it.tag, obs, it.exp);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype();
        push("r_fetch",  RT, 1, 1, 1, e_fetch(1));
        push("r_decode", RT, 1, 1, 1, e_decode(0));
        push("r_exec",   RT, 1, 1, 1, E_REXEC);
        push("r_wb",     RT, 1, 1, 1, E_RWB);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            opcode = it.op; mem_ready = it.rdy; alu_zero = it.zero; alu_neg = it.neg;
            @(negedge clk);
            total++;
            if (obs !== it.exp) $display("FAIL %s: got %b expected %b", it.tag, obs, it.exp);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        push_branch("beq_z1",     BEQ,  1, 0, 1);
        push_branch("beq_z0",     BEQ,  0, 0, 0);
        push_branch("bne_z1",     BNE,  1, 0, 0);
        push_branch("bne_z0",     BNE,  0, 1, 1);
        push_branch("bgtz_z0n1",  BGTZ, 0, 1, 0);
        push_branch("bgtz_z0n0",  BGTZ, 0, 0, 1);
        push_branch("bgtz_z1n0",  BGTZ, 1, 0, 0);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            opcode = it.op; mem_ready = it.rdy; alu_zero = it.zero; alu_neg = it.neg;
            @(negedge clk);
            total++;
            if (obs !== it.exp) $display("FAIL %s: got %b expected %b", it.tag, obs, it.exp);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_wait();
        push("sw_fetch",  SW, 1, 0, 0, e_fetch(1));
        push("sw_decode", SW, 0, 0, 0, e_decode(0));
        push("sw_addr",   SW, 0, 0, 0, E_ADDR);
        for (int i = 0; i < 3; i++) push("sw_wait", SW, 0, 0, 0, e_memwr(0));
        push("sw_ready",  SW, 1, 0, 0, e_memwr(1));
        push("sw_next_fetch", RT, 0, 0, 0, e_fetch(0));
        while (sb.size() > 0) begin
            it = sb.pop_front();
            opcode = it.op; mem_ready = it.rdy; alu_zero = it.zero; alu_neg = it.neg;
            @(negedge clk);
            total++;
            if (obs !== it.exp) $display("FAIL %s: got %b expected %b", it.tag, obs, it.exp);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        push("ill_fetch",  6'b111111, 1, 0, 0, e_fetch(1));
        push("ill_decode", 6'b111111, 1, 0, 0, e_decode(1));
        push("ill_refetch", 6'b111111, 0, 0, 0, e_fetch(0));
        push("ill_refetch2", 6'b111111, 1, 0, 0, e_fetch(1));
        push("ill2_decode", 6'b010001, 1, 0, 0, e_decode(1));
        while (sb.size() > 0) begin
            it = sb.pop_front();
            opcode = it.op; mem_ready = it.rdy; alu_zero = it.zero; alu_neg = it.neg;
            @(negedge clk);
            total++;
            if (obs !== it.exp) $display("FAIL %s: got %b expected %b", it.tag, obs, it.exp);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        push("addi_fetch",  ADDI, 1, 0, 0, e_fetch(1));
        push("addi_decode", ADDI, 1, 0, 0, e_decode(0));
        push("addi_exec",   ADDI, 1, 0, 0, E_ADDR);
        push("addi_wb",     ADDI, 1, 0, 0, E_ADDIWB);
        push("j_fetch",     JMP,  1, 0, 0, e_fetch(1));
        push("j_decode",    JMP,  1, 0, 0, e_decode(0));
        push("j_jump",      JMP,  0, 0, 0, E_JUMP);
        push("r_fetch_w0",  RT,   0, 0, 0, e_fetch(0));
        push("r_fetch_w1",  RT,   0, 0, 0, e_fetch(0));
        push("r_fetch_rdy", RT,   1, 0, 0, e_fetch(1));
        push("r_decode",    RT,   0, 0, 0, e_decode(0));
        push("r_exec",      RT,   0, 0, 0, E_REXEC);
        push("r_wb",        RT,   0, 0, 0, E_RWB);
        push("lw2_fetch",   LW,   1, 0, 0, e_fetch(1));
        push("lw2_decode",  LW,   1, 0, 0, e_decode(0));
        push("lw2_addr",    LW,   1, 0, 0, E_ADDR);
        push("lw2_wait",    LW,   0, 0, 0, E_MEMRD);
        push("lw2_memrd",   LW,   1, 0, 0, E_MEMRD);
        push("lw2_memwb",   LW,   1, 0, 0, E_MEMWB);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            opcode = it.op; mem_ready = it.rdy; alu_zero = it.zero; alu_neg = it.neg;
            @(negedge clk);
            total++;
            if (obs !== it.exp) $display("FAIL %s: got %b expected %b", it.tag, obs, it.exp);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        push("rm_fetch",  LW, 1, 0, 0, e_fetch(1));
        push("rm_decode", LW, 1, 0, 0, e_decode(0));
        push("rm_addr",   LW, 1, 0, 0, E_ADDR);
        push("rm_memrd",  LW, 0, 0, 0, E_MEMRD);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            opcode = it.op; mem_ready = it.rdy; alu_zero = it.zero; alu_neg = it.neg;
            @(negedge clk);
            total++;
            if (obs !== it.exp) $display("FAIL %s: got %b expected %b", it.tag, obs, it.exp);
            else passed++;
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs !== E_IDLE) $display("FAIL rm_async_abort: got %b expected %b", obs, E_IDLE);
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        push("rm_idle",    LW, 1, 0, 0, E_IDLE);
        push("rm_restart", LW, 0, 0, 0, e_fetch(0));
        while (sb.size() > 0) begin
            it = sb.pop_front();
            opcode = it.op; mem_ready = it.rdy; alu_zero = it.zero; alu_neg = it.neg;
            @(negedge clk);
            total++;
            if (obs !== it.exp) $display("FAIL %s: got %b expected %b", it.tag, obs, it.exp);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", total);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_branch();
        test_sw_wait();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Multicycle main controller FSM; the producer side of the ALUop interface that alu_control consumes.
- Decodes opcode/zero/sign and sequences fetch, decode, execute, memory and writeback cycles.
- Drives ALUop[1:0] plus all datapath enables, muxes and write strobes.
- Sits beside alu_control; ALUop feeds alu_control directly.

Parameters:
- ST_W, 4, state register width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instruction[31:26] from IR
- alu_zero  in  1  ALU result == 0
- alu_neg  in  1  ALU result bit 31
- mem_ready  in  1  memory access complete this cycle
- ALUop  out  2  00 add, 01 sub, 10 R-type (use func)
- alu_src_a  out  1  0 PC, 1 regA
- alu_src_b  out  2  00 regB, 01 const 4, 10 signext imm, 11 signext imm<<2
- pc_write  out  1  PC load enable, branch condition already folded in
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- iord  out  1  0 PC address, 1 ALUOut address
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load enable
- reg_dst  out  1  0 rt, 1 rd
- mem_to_reg  out  1  0 ALUOut, 1 MDR
- reg_write  out  1  register file write enable
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal_op  out  1  one-cycle pulse when decode finds an unsupported opcode

Behaviour:
- Output style: Moore outputs decoded from state. Exceptions are pc_write, ir_write, instr_done and illegal_op, which are qualified as stated below.
- Reset: state=IDLE and every output 0, asynchronously. IDLE goes to FETCH on the first clock edge after rst_n deasserts.
- FETCH:
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, ALUop=00, pc_source=00.
  - Holds while mem_ready=0.
  - When mem_ready=1: ir_write=1, pc_write=1, next state DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, ALUop=00 (branch target into ALUOut). Next state by opcode:
  - 000000 → R_EXEC
  - 100011 / 101011 → MEM_ADDR
  - 001000 → ADDI_EXEC
  - 000100 / 000101 / 000111 → BRANCH
  - 000010 → JUMP
  - any other opcode → FETCH, with illegal_op=1 and instr_done=1
- R_EXEC: alu_src_a=1, alu_src_b=00, ALUop=10 → R_WB.
- R_WB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1 → FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ALUop=00. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1. Holds until mem_ready=1, then → MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1 → FETCH.
- MEM_WR: mem_write=1, iord=1. Holds until mem_ready=1; instr_done=1 in the ready cycle → FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, ALUop=00 → ADDI_WB.
- ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1 → FETCH.
- BRANCH:
  - Drives alu_src_a=1, alu_src_b=00, ALUop=01, pc_source=01, instr_done=1 → FETCH.
  - pc_write condition:
    - beq: alu_zero
    - bne: !alu_zero
    - bgtz: !alu_zero && !alu_neg
  - opcode is read from the IR, which is stable during BRANCH.
- JUMP: pc_source=10, pc_write=1, instr_done=1 → FETCH.
- Cycle counts with mem_ready tied high:
  - R-type / addi: 4
  - lw: 5
  - sw: 4
  - branch / jump: 3
- Each memory wait cycle adds 1.
- mem_ready in a non-memory state is ignored.
- rst_n asserted mid-instruction aborts immediately to IDLE; no pending writes are issued.
- Unreachable state encodings recover to IDLE.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_BNE, OP_BGTZ, OP_J)
  - ALUop constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNC=10)
  - the state enumeration
- alu_control imports the same ALUop constants.
- Sub-module branch_cond: opcode, alu_zero, alu_neg → take.

Test Plan:
- Reset, then lw (opcode 100011) with mem_ready high → IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB; reg_write=1 and mem_to_reg=1 only in MEM_WB; instr_done once.
- R-type (000000) → ALUop=10 in R_EXEC; reg_dst=1, reg_write=1 in the fourth cycle; ALUop=00 in FETCH and DECODE.
- beq with alu_zero=1 → pc_write=1, pc_source=01 in BRANCH. bne with alu_zero=1 → pc_write=0. bgtz with zero=0, neg=1 → pc_write=0.
- sw with mem_ready low for 3 cycles in MEM_WR → mem_write held 4 cycles, instr_done only in the ready cycle, total 7 cycles.
- Opcode 111111 → illegal_op pulse in DECODE, return to FETCH, no reg_write or mem_write.
- rst_n low during MEM_RD → all outputs 0 immediately; after release, restart at FETCH with mem_read=1.
